oam_dma_ctrl: RTL and testbench

Sprite-DMA sequencer and memory-bus owner between the 6502 core and the shared memory/register bus.
- A CPU write to the DMA trigger register latches a source page and stalls the CPU through cpu_rdy.
- The block then copies 256 bytes from {page, 8'h00}..{page, 8'hFF} to the OAM data port, one read/write pair per byte.
- Outside DMA, the block is a transparent pass-through from CPU to memory bus.

---
 rtl/oam_dma_ctrl_if.sv | 25 ++
 rtl/oam_dma_ctrl.sv | 91 +++++++++
 tb/tb_oam_dma_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU-side and memory-side bus bundle for the sprite DMA sequencer
interface oam_dma_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
) ();
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_wdata;
  logic                  cpu_we;
  logic                  cpu_rdy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic                  mem_we;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic                  dma_active;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_rdy, mem_addr, mem_wdata, mem_we, dma_active
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_rdy, mem_addr, mem_wdata, mem_we, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer and memory-bus owner between the CPU and the shared bus
module oam_dma_ctrl #(
  parameter int                    REG_WIDTH     = 8,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004,
  parameter int                    DMA_LEN       = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  oam_dma_ctrl_if.slave bus
);
  localparam int IDX_W = ADDR_WIDTH - REG_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] page_q, page_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 parity_q, parity_d;
  logic                 cpu_rdy_q, cpu_rdy_d;
  logic                 dma_active_q, dma_active_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    parity_d = ~parity_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = bus.cpu_wdata;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT:  state_d = parity_q ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        // idx wraps within the page; the page register is never incremented
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) begin
      state_d  = IDLE;
      page_d   = '0;
      idx_d    = '0;
      parity_d = 1'b0;
    end
    cpu_rdy_d    = (state_d == IDLE);
    dma_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    page_q       <= page_d;
    idx_q        <= idx_d;
    parity_q     <= parity_d;
    cpu_rdy_q    <= cpu_rdy_d;
    dma_active_q <= dma_active_d;
  end

  // The bus mux has to stay combinational so IDLE is a zero-latency pass-through
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_we    = 1'b0;
    case (state_q)
      IDLE:  bus.mem_we = bus.cpu_we;
      READ:  bus.mem_addr = {page_q, idx_q};
      WRITE: begin
        bus.mem_addr  = OAM_DATA_ADDR;
        bus.mem_wdata = bus.mem_rdata;
        bus.mem_we    = 1'b1;
      end
      default: bus.mem_we = 1'b0;
    endcase
  end

  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.dma_active = dma_active_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for the sprite DMA sequencer
module tb_oam_dma_ctrl;
  logic clk;
  logic reset_n;
  oam_dma_ctrl_if bus ();

  oam_dma_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    logic [15:0] w;
    w = a[15:0];
    if (w[15:8] == 8'h02) return w[7:0] ^ 8'hA5;
    return w[7:0] ^ w[15:8] ^ 8'h5A;
  endfunction

  // Memory model: registered read, OAM port writes are not stored
  logic [7:0] mem [0:65535];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (mem_ready !== 1'b1) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(a);
      mem_ready <= 1'b1;
    end else if (bus.mem_we === 1'b1 && bus.mem_addr != 16'h2004) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference parity phase: 0 during reset and in the first cycle after release
  logic tb_par = 1'b0;
  always @(posedge clk) tb_par <= reset_n ? ~tb_par : 1'b0;

  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_data_q [$];
  int          exp_stall_q [$];

  int          oam_count = 0;
  int          zero_reads = 0;
  logic        first_par = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  int          run_len = 0;
  bit          abort_run = 1'b0;

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    int          es;
    if (bus.mem_we === 1'b1 && bus.mem_addr == 16'h2004) begin
      oam_count++;
      if (exp_data_q.size() == 0) begin
        check("oam_unexp", 32'd1, 32'd0);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("oam_data", {24'd0, bus.mem_wdata}, {24'd0, ed});
        check("oam_src", {16'd0, prev_addr}, {16'd0, ea});
      end
      if (prev_addr[7:0] == 8'h00) first_par = ~tb_par;
    end else if (bus.dma_active === 1'b1 && bus.mem_we === 1'b1) begin
      check("dma_stray_we", {16'd0, bus.mem_addr}, 32'h2004);
    end
    if (bus.dma_active === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr == 16'h0000) zero_reads++;
    if (bus.cpu_rdy === 1'b0) begin
      run_len++;
      if (!reset_n) abort_run = 1'b1;
    end else if (bus.cpu_rdy === 1'b1) begin
      if (run_len > 0) begin
        if (exp_stall_q.size() == 0) begin
          check("stall_unexp", run_len, 0);
        end else begin
          es = exp_stall_q.pop_front();
          if (!abort_run) check("stall_len", run_len, es);
        end
      end
      run_len = 0;
      abort_run = 1'b0;
    end
    prev_addr = bus.mem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // want_halt_par < 0 triggers in the current cycle regardless of phase
  task automatic start_dma(input logic [7:0] page, input int want_halt_par);
    if (want_halt_par >= 0) begin
      while (tb_par == want_halt_par[0]) step();
    end
    exp_stall_q.push_back(tb_par ? 513 : 514);
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back({page, i[7:0]});
      exp_data_q.push_back(mem[{page, i[7:0]}]);
    end
    bus.cpu_addr  = 16'h4014;
    bus.cpu_wdata = page;
    bus.cpu_we    = 1'b1;
    step();
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h1234;
    bus.cpu_wdata = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (bus.cpu_rdy === 1'b1 && exp_data_q.size() == 0 && exp_stall_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  int   base;
  logic par_even;
  bit   ok;

  initial begin
    bus.cpu_addr  = 16'h1234;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    reset_n       = 1'b0;
    repeat (3) step();
    check("rst_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("rst_active", {31'd0, bus.dma_active}, 32'd0);
    check("rst_passthru", {16'd0, bus.mem_addr}, 32'h1234);
    reset_n = 1'b1;
    step();

    base = oam_count;
    start_dma(8'h02, 0);
    wait_done("even_done");
    check("even_count", oam_count - base, 256);
    par_even = first_par;

    base = oam_count;
    start_dma(8'h02, 1);
    wait_done("odd_done");
    check("odd_count", oam_count - base, 256);
    check("read_phase", {31'd0, first_par}, {31'd0, par_even});

    base = oam_count;
    zero_reads = 0;
    start_dma(8'hFF, -1);
    wait_done("wrap_done");
    check("wrap_count", oam_count - base, 256);
    check("wrap_zero_reads", zero_reads, 0);

    bus.cpu_addr  = 16'h0010;
    bus.cpu_wdata = 8'h3C;
    bus.cpu_we    = 1'b1;
    #1;
    check("pt_we", {31'd0, bus.mem_we}, 32'd1);
    check("pt_addr", {16'd0, bus.mem_addr}, 32'h0010);
    check("pt_wdata", {24'd0, bus.mem_wdata}, 32'h3C);
    check("pt_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("pt_active", {31'd0, bus.dma_active}, 32'd0);
    step();
    bus.cpu_we = 1'b0;
    step();
    check("pt_rdata", {24'd0, bus.mem_rdata}, 32'h3C);
    check("pt_rdy2", {31'd0, bus.cpu_rdy}, 32'd1);
    bus.cpu_addr = 16'h1234;

    base = oam_count;
    start_dma(8'h02, -1);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (oam_count - base >= 100) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("abort_reach", {31'd0, ok}, 32'd1);
    reset_n = 1'b0;
    step();
    check("abort_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("abort_active", {31'd0, bus.dma_active}, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    reset_n = 1'b1;
    repeat (600) step();
    check("abort_count", oam_count - base, 100);

    base = oam_count;
    start_dma(8'h03, -1);
    wait_done("after_rst_done");
    check("after_rst_count", oam_count - base, 256);

    base = oam_count;
    start_dma(8'h02, -1);
    repeat (100) step();
    bus.cpu_addr  = 16'h4014;
    bus.cpu_wdata = 8'h05;
    bus.cpu_we    = 1'b1;
    step();
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h1234;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (bus.cpu_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_end", {31'd0, ok}, 32'd1);
    start_dma(8'h03, -1);
    wait_done("b2b_done");
    check("b2b_count", oam_count - base, 512);

    repeat (20) step();
    check("final_data_q", exp_data_q.size(), 0);
    check("final_stall_q", exp_stall_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
